// File: rtl/nor_seq_pkg.sv
// Shared types and helpers for the time-multiplexed NOR chain sequencer.
package nor_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  function automatic int cnt_width(input int stages);
    return $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/nor2_cell.sv
// Single combinational 2-input NOR; the one shared evaluation resource.
module nor2_cell (
  input  logic x,
  input  logic y,
  output logic z
);

  assign z = ~(x | y);

endmodule

// File: rtl/nor_chain_sequencer.sv
// Evaluates a cascaded NOR chain one stage per clock through a single shared NOR
// cell, with valid/ready handshakes on the operand and result sides.
module nor_chain_sequencer
  import nor_seq_pkg::*;
#(
  parameter int STAGES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [STAGES:0]   ops,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [STAGES-1:0] taps,
  output logic              result,
  output logic              busy
);

  localparam int CNT_W = cnt_width(STAGES);

  seq_state_t       state, next_state;
  logic [CNT_W-1:0] cnt;
  logic [STAGES:0]  ops_q;
  logic [STAGES-1:0] taps_q;
  logic             nor_x, nor_y, nor_z;
  logic             accept, last_stage;

  nor2_cell u_nor (
    .x(nor_x),
    .y(nor_y),
    .z(nor_z)
  );

  assign accept     = (state == IDLE) && in_valid;
  assign last_stage = (cnt == CNT_W'(STAGES - 1));

  // Stage 0 combines a and b; every later stage combines the previous tap with its side operand.
  always_comb begin
    nor_x = ops_q[0];
    nor_y = ops_q[1];
    for (int k = 1; k < STAGES; k++) begin
      if (cnt == CNT_W'(k)) begin
        nor_x = taps_q[k-1];
        nor_y = ops_q[k+1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_stage) next_state = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Taps persist through DONE and IDLE; they are only cleared by the next accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      ops_q  <= '0;
      taps_q <= '0;
    end else if (accept) begin
      cnt    <= '0;
      ops_q  <= ops;
      taps_q <= '0;
    end else if (state == RUN) begin
      for (int k = 0; k < STAGES; k++) begin
        if (cnt == CNT_W'(k)) taps_q[k] <= nor_z;
      end
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign taps   = taps_q;
  assign result = taps_q[STAGES-1];

endmodule

// File: tb/tb_nor_chain_sequencer.sv
// Randomized self-checking bench for nor_chain_sequencer (STAGES=3 and STAGES=1 builds).
module tb_nor_chain_sequencer;

  logic clk;
  logic rst;

  logic       s3_in_valid, s3_in_ready, s3_out_valid, s3_out_ready, s3_result, s3_busy;
  logic [3:0] s3_ops;
  logic [2:0] s3_taps;

  logic       s1_in_valid, s1_in_ready, s1_out_valid, s1_out_ready, s1_result, s1_busy;
  logic [1:0] s1_ops;
  logic [0:0] s1_taps;

  int vectors = 0;
  int miscompares = 0;

  nor_chain_sequencer #(.STAGES(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .in_valid(s3_in_valid), .in_ready(s3_in_ready), .ops(s3_ops),
    .out_valid(s3_out_valid), .out_ready(s3_out_ready),
    .taps(s3_taps), .result(s3_result), .busy(s3_busy)
  );

  nor_chain_sequencer #(.STAGES(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_valid(s1_in_valid), .in_ready(s1_in_ready), .ops(s1_ops),
    .out_valid(s1_out_valid), .out_ready(s1_out_ready),
    .taps(s1_taps), .result(s1_result), .busy(s1_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Chain reference: e = ~(a|b), then each stage NORs the previous tap with the next operand.
  function automatic logic [31:0] model_taps(input int stages, input logic [31:0] v);
    logic [31:0] t;
    logic prev;
    t = '0;
    prev = ~(v[0] | v[1]);
    t[0] = prev;
    for (int k = 1; k < stages; k++) begin
      prev = ~(prev | v[k+1]);
      t[k] = prev;
    end
    return t;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] v, input int hold, input bit inject);
    int cyc;
    logic [31:0] exp;
    exp = model_taps(3, {28'd0, v});
    cyc = 0;
    while (!s3_in_ready && cyc < 20) begin step(); cyc++; end
    checkOutput("s3_ready_before_accept", {31'd0, s3_in_ready}, 32'd1);
    s3_ops = v;
    s3_in_valid = 1'b1;
    step();
    s3_in_valid = 1'b0;
    checkOutput("s3_busy_after_accept", {31'd0, s3_busy}, 32'd1);
    checkOutput("s3_taps_cleared", {29'd0, s3_taps}, 32'd0);
    checkOutput("s3_in_ready_run", {31'd0, s3_in_ready}, 32'd0);
    if (inject) begin
      s3_in_valid = 1'b1;
      s3_ops = 4'b1111;
    end
    cyc = 0;
    while (!s3_out_valid && cyc < 20) begin step(); cyc++; end
    s3_in_valid = 1'b0;
    checkOutput("s3_latency", cyc, 32'd3);
    checkOutput("s3_taps", {29'd0, s3_taps}, {29'd0, exp[2:0]});
    checkOutput("s3_result", {31'd0, s3_result}, {31'd0, exp[2]});
    for (int h = 0; h < hold; h++) begin
      step();
      checkOutput("s3_hold_valid", {31'd0, s3_out_valid}, 32'd1);
      checkOutput("s3_hold_taps", {29'd0, s3_taps}, {29'd0, exp[2:0]});
      checkOutput("s3_hold_in_ready", {31'd0, s3_in_ready}, 32'd0);
    end
    s3_out_ready = 1'b1;
    step();
    s3_out_ready = 1'b0;
    checkOutput("s3_valid_dropped", {31'd0, s3_out_valid}, 32'd0);
    checkOutput("s3_back_idle", {31'd0, s3_in_ready}, 32'd1);
    checkOutput("s3_idle_not_busy", {31'd0, s3_busy}, 32'd0);
    checkOutput("s3_taps_kept", {29'd0, s3_taps}, {29'd0, exp[2:0]});
  endtask

  task automatic applyStimulus1(input logic [1:0] v);
    int cyc;
    logic [31:0] exp;
    exp = model_taps(1, {30'd0, v});
    s1_ops = v;
    s1_in_valid = 1'b1;
    step();
    s1_in_valid = 1'b0;
    cyc = 0;
    while (!s1_out_valid && cyc < 20) begin step(); cyc++; end
    checkOutput("s1_latency", cyc, 32'd1);
    checkOutput("s1_result", {31'd0, s1_result}, {31'd0, exp[0]});
    s1_out_ready = 1'b1;
    step();
    s1_out_ready = 1'b0;
    checkOutput("s1_back_idle", {31'd0, s1_in_ready}, 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    s3_in_valid = 1'b0; s3_out_ready = 1'b0; s3_ops = '0;
    s1_in_valid = 1'b0; s1_out_ready = 1'b0; s1_ops = '0;
    #2;
    checkOutput("rst_in_ready", {31'd0, s3_in_ready}, 32'd1);
    checkOutput("rst_out_valid", {31'd0, s3_out_valid}, 32'd0);
    checkOutput("rst_busy", {31'd0, s3_busy}, 32'd0);
    checkOutput("rst_taps", {29'd0, s3_taps}, 32'd0);
    checkOutput("rst_result", {31'd0, s3_result}, 32'd0);
    checkOutput("rst_s1_in_ready", {31'd0, s1_in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // out_ready while idle must not disturb anything
    s3_out_ready = 1'b1;
    step();
    s3_out_ready = 1'b0;
    checkOutput("idle_out_ready_ignored", {30'd0, s3_in_ready, s3_out_valid}, 32'd2);

    applyStimulus(4'b0000, 0, 1'b0);
    applyStimulus(4'b0001, 0, 1'b0);
    applyStimulus(4'b1000, 5, 1'b0);
    applyStimulus(4'b0110, 1, 1'b1);
    applyStimulus(4'b1111, 0, 1'b0);

    // reset in the middle of RUN discards the in-flight vector
    s3_ops = 4'b0000;
    s3_in_valid = 1'b1;
    step();
    s3_in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
    checkOutput("midrun_rst_in_ready", {31'd0, s3_in_ready}, 32'd1);
    checkOutput("midrun_rst_out_valid", {31'd0, s3_out_valid}, 32'd0);
    checkOutput("midrun_rst_busy", {31'd0, s3_busy}, 32'd0);
    checkOutput("midrun_rst_taps", {29'd0, s3_taps}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      checkOutput("midrun_no_valid_pulse", {31'd0, s3_out_valid}, 32'd0);
    end

    for (int i = 0; i < 24; i++) begin
      applyStimulus(4'($urandom()), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    applyStimulus1(2'b00);
    applyStimulus1(2'b10);
    for (int i = 0; i < 8; i++) begin
      applyStimulus1(2'($urandom()));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nor_chain_sequencer.md
Name: nor_chain_sequencer

Overview:
Iterative, time-multiplexed evaluator for the cascaded NOR chain used in the gate-level labs. Stage 0 computes e = ~(a|b). Each later stage k computes ~(previous tap | next operand).
The block holds one shared 2-input NOR cell and steps it through STAGES evaluations, one per clock. It accepts operand vectors and returns the result over valid/ready handshakes.
It sits between a stimulus source (switch/test driver) and a result consumer (LED/display driver or bench monitor).

Parameters:
STAGES, 3, number of chained NOR stages (>=1); default gives the e,f,g chain
CNT_W, $clog2(STAGES+1), width of the internal stage counter (derived; not overridden)

Ports:
clk  input  1  single system clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand vector present
in_ready  output  1  block can accept operands
ops  input  STAGES+1  operands: ops[0]=a, ops[1]=b, ops[k+1]=side operand of stage k (k>=1)
out_valid  output  1  result and taps are valid
out_ready  input  1  consumer accepts the result
taps  output  STAGES  per-stage results: taps[0]=e, taps[1]=f, taps[2]=g, ...
result  output  1  taps[STAGES-1]
busy  output  1  high in RUN or DONE

Behaviour:
- States: IDLE, RUN, DONE (2-bit encoding).
- Reset (async assert, released synchronously by the flop clocking): state=IDLE, taps=0, stage counter=0, operand register=0.
- Reset output values: in_ready=1, out_valid=0, busy=0, result=0.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at an edge: latch ops, clear taps, counter=0, go to RUN.
- RUN:
  - in_ready=0; in_valid is ignored and ops are not sampled.
  - Each edge: taps[cnt] <= ~(x | y), via the shared NOR cell.
    - cnt==0: x=ops_q[0], y=ops_q[1].
    - cnt>0: x=taps[cnt-1], y=ops_q[cnt+1].
  - Then cnt<=cnt+1.
  - The edge that writes taps[STAGES-1] also moves state to DONE.
  - Taps not yet computed read 0.
- DONE:
  - out_valid=1; taps and result are stable.
  - Holds indefinitely while out_ready=0.
  - On out_valid&out_ready at an edge: go to IDLE. Taps keep their values until the next accept.
- Latency: accept edge at cycle T; out_valid is first high in the cycle after edge T+STAGES, i.e. STAGES clocks after acceptance. Throughput is one vector per STAGES+2 cycles at best.
- out_valid, in_ready and busy are decoded from registered state only; there are no combinational input-to-output paths.
- STAGES=1: a single RUN cycle; no side operands are used.
- Reset asserted mid-RUN or mid-DONE: immediate return to IDLE with outputs at their reset values. The in-flight result is discarded and out_valid never pulses.
- out_ready high while not in DONE: no effect.

Decomposition:
- Shared package nor_seq_pkg:
  - state localparams IDLE=2'd0, RUN=2'd1, DONE=2'd2
  - helper for CNT_W
- One sub-module, nor2_cell: a purely combinational 2-input NOR (x, y -> z). It is instantiated once and is the shared resource the FSM schedules.
- Everything else (FSM, counter, operand/tap registers) lives in the top module.

Test Plan:
- Reset, then ops=4'b0000 accepted -> out_valid rises 3 clocks later; taps=3'b101, result=1.
- ops=4'b0001 (a=1) -> taps=3'b010, result=0. Also, one cycle after accept, taps=3'b000 and busy=1.
- ops=4'b1000 (d=1) with out_ready held low 5 cycles -> out_valid stays 1 and taps=3'b001 stable for all 5 cycles; in_ready=0 throughout; a single handshake on out_ready.
- During RUN, drive in_valid=1 with ops=4'b1111 -> ignored; the result matches the originally accepted vector. The block accepts 4'b1111 only after returning to IDLE; then taps=3'b000, result=0.
- Assert rst for 1 cycle at RUN cycle 2 -> same cycle: in_ready=1, out_valid=0, busy=0, taps=0; no out_valid pulse follows.
- STAGES=1 build, ops=2'b00 -> out_valid 1 clock after accept, result=1; ops=2'b10 -> result=0.
